vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the raster timing stream (hcount, vcount, hsync, vsync, hblnk, vblnk) that every draw_* stage in the VGA pipeline consumes. It sits at the head of the pipeline. It is clocked by the pixel clock (65 MHz for 1024x768@60, VESA) and drives the first draw stage directly. It also provides a frame-start strobe and a free-running frame counter for game-logic/animation pacing.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
HS_POL, 0, active level of hsync (0 = active-low, VESA 1024x768@60)
VS_POL, 0, active level of vsync

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  pixel-advance enable; low = freeze raster
hcount  out  12  horizontal position, 0..H_TOTAL-1
vcount  out  12  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
hblnk  out  1  high outside visible columns
vblnk  out  1  high outside visible lines
frame_start  out  1  one-cycle strobe on entry to (0,0)
frame_cnt  out  16  frames completed since reset, wraps

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Reset is synchronous, active-high, and overrides en. On reset: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, frame_start=0, frame_cnt=0.
- All outputs are registered. hsync, vsync, hblnk and vblnk are decoded from the next-state counts in the same cycle. At every edge they are therefore an exact function of the hcount/vcount they accompany, with zero skew. Reset values satisfy that function.
- Horizontal decode:
  - hblnk=1 iff hcount >= H_ACTIVE.
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC. Default range is 1048..1183.
- Vertical decode:
  - vblnk=1 iff vcount >= V_ACTIVE.
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. Default range is 771..776.
- On each pclk edge with rst=0 and en=1:
  - hcount increments.
  - At hcount=H_TOTAL-1, hcount wraps to 0 and vcount increments at the same edge.
  - At vcount=V_TOTAL-1 together with the hcount wrap, vcount wraps to 0 at the same edge.
- en=0: all counts and decoded outputs hold their current values, frame_start is forced to 0, and frame_cnt holds. en may toggle on any cycle.
- frame_start:
  - Registered; high for exactly one cycle, the cycle in which the outputs first show (0,0) after an en-qualified step from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the (0,0) state produced by reset.
  - If en drops while frame_start=1, frame_start falls on the next edge and is not re-asserted.
- frame_cnt increments on the same edge that sets frame_start and wraps 0xFFFF -> 0x0000.
- Reset mid-frame returns everything to the reset state on the next edge. No partial-line flush and no frame_start strobe.
- Width rule: counters are 12 bits. H_TOTAL and V_TOTAL must be <= 4096, and parameters violating this are unsupported. All comparisons are unsigned.
- Frame period at default parameters with en tied high: 1344*806 = 1,083,264 pclk cycles.

Decomposition:
- Package vga_timing_pkg holds:
  - the VESA 1024x768@60 constants (H_/V_ ACTIVE/FP/SYNC/BP, polarities);
  - derived H_TOTAL/V_TOTAL;
  - the count width (12).
- Sub-module vga_axis_counter is a generic wrap counter with blank/sync decode, parameterised by ACTIVE/FP/SYNC/BP/POL.
  - It has an increment-enable input and a terminal-count output.
  - It is instantiated twice: horizontal with inc=en; vertical with inc=en & h_terminal.
- frame_start/frame_cnt logic lives in the top.

Test Plan:
- Hold rst=1 for 5 cycles, then release with en=1 -> during reset hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=1, vsync=1 (default POL=0), frame_cnt=0. The first edge after release gives hcount=1.
- Free-run one line -> hblnk rises at hcount=1024. hsync is low for hcount 1048..1183 (exactly 136 cycles). hcount 1343 is followed by 0 with vcount 0->1.
- Free-run one frame -> vblnk is high for vcount 768..805 and vsync is low for vcount 771..776. (1343,805) is followed by (0,0) with frame_start=1 for one cycle and frame_cnt=1. The next frame_start comes 1,083,264 cycles later.
- Drive en=0 for 10 cycles at hcount=1100 (inside hsync) -> all outputs frozen, frame_start=0. Resume gives hcount=1101, and the hsync pulse still totals 136 enabled cycles.
- Drop en on the frame_start cycle -> frame_start falls next edge, frame_cnt does not increment again, and the (0,0) outputs hold.
- Assert rst at (700,400) with frame_cnt=3 -> next edge gives (0,0), frame_cnt=0, frame_start=0. Force frame_cnt=0xFFFF and complete a frame -> frame_cnt wraps to 0x0000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster generator: VESA 1024x768@60 timing,
// derived frame geometry and counter widths.
package vga_timing_pkg;

  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b0;

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle handed from the timing generator to the first draw stage.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0]  hcount;
  logic [CNT_W-1:0]  vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered blank/sync decoded
// from the next-state count, so decode and count always change on the same edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter bit POL    = 1'b0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             blnk_o,
  output logic             sync_o,
  output logic             term_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // One extra bit keeps the sync bounds exact even when a bound equals 2**CNT_W.
  localparam logic [CNT_W:0] LAST_W     = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] ACTIVE_W   = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] SYNC_BEG_W = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0] SYNC_END_W = (CNT_W+1)'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;
  logic [CNT_W:0]   cnt_d_w;

  assign term_o = ({1'b0, cnt_q} == LAST_W);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = term_o ? '0 : cnt_q + 1'b1;
    end
    cnt_d_w = {1'b0, cnt_d};
    blnk_d  = (cnt_d_w >= ACTIVE_W);
    sync_d  = ((cnt_d_w >= SYNC_BEG_W) && (cnt_d_w < SYNC_END_W)) ? POL : ~POL;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign blnk_o = blnk_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the VGA pipeline: horizontal/vertical raster timing plus a frame-start
// strobe and a free-running frame counter for animation pacing.
module vga_timing_gen
  import vga_timing_pkg::CNT_W;
  import vga_timing_pkg::FCNT_W;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit HS_POL   = vga_timing_pkg::HS_POL,
  parameter bit VS_POL   = vga_timing_pkg::VS_POL
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     en_i,
  vga_timing_gen_if.master         vga_o
);

  logic              h_term, v_term;
  logic              frame_wrap;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL)
  ) u_h_axis (
    .pclk   (pclk),
    .rst    (rst),
    .inc_i  (en_i),
    .cnt_o  (vga_o.hcount),
    .blnk_o (vga_o.hblnk),
    .sync_o (vga_o.hsync),
    .term_o (h_term)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL)
  ) u_v_axis (
    .pclk   (pclk),
    .rst    (rst),
    .inc_i  (en_i & h_term),
    .cnt_o  (vga_o.vcount),
    .blnk_o (vga_o.vblnk),
    .sync_o (vga_o.vsync),
    .term_o (v_term)
  );

  // The strobe follows only an enabled step out of the last pixel, so a frozen
  // raster drops it after one cycle and reset's (0,0) never raises it.
  always_comb begin
    frame_wrap    = en_i & h_term & v_term;
    frame_start_d = frame_wrap;
    frame_cnt_d   = frame_cnt_q + FCNT_W'(frame_wrap);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga_o.frame_start = frame_start_q;
  assign vga_o.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (25x10) so whole
// frames fit in a short run: hblnk 16..24, hsync low 18..20, vblnk 6..9, vsync low 7..8.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b1;

  int passed = 0;
  int total  = 0;

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut (
    .pclk  (pclk),
    .rst   (rst),
    .en_i  (en),
    .vga_o (vga)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input int h, input int v, input bit hb, input bit vb,
                           input bit hs, input bit vs, input bit fs, input int fc);
    check({tag, ".hcount"},      32'(vga.hcount),      32'(h));
    check({tag, ".vcount"},      32'(vga.vcount),      32'(v));
    check({tag, ".hblnk"},       32'(vga.hblnk),       32'(hb));
    check({tag, ".vblnk"},       32'(vga.vblnk),       32'(vb));
    check({tag, ".hsync"},       32'(vga.hsync),       32'(hs));
    check({tag, ".vsync"},       32'(vga.vsync),       32'(vs));
    check({tag, ".frame_start"}, 32'(vga.frame_start), 32'(fs));
    check({tag, ".frame_cnt"},   32'(vga.frame_cnt),   32'(fc));
  endtask

  // Waits for the next frame_start; returns the number of ticks taken, or -1 on timeout.
  task automatic wait_frame_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (vga.frame_start !== 1'b1 && n < 1000);
    if (vga.frame_start !== 1'b1) n = -1;
  endtask

  logic [9:0] vblnk_tab = 10'b11_1100_0000;
  logic [9:0] vsync_tab = 10'b10_0111_1111;
  int n;
  int low_cnt;

  initial begin
    // Reset held with en high: reset wins.
    tick(5);
    check_all("reset", 0, 0, 0, 0, 1, 1, 0, 0);

    rst = 1'b0;
    tick();
    check("release.hcount", 32'(vga.hcount), 32'd1);
    check("release.vcount", 32'(vga.vcount), 32'd0);

    // Horizontal blank/sync edges on line 0.
    tick(14);
    check_all("h15", 15, 0, 0, 0, 1, 1, 0, 0);
    tick();
    check_all("h16", 16, 0, 1, 0, 1, 1, 0, 0);
    tick();
    check("h17.hsync", 32'(vga.hsync), 32'd1);
    tick();
    low_cnt = 0;
    while (vga.hsync === 1'b0 && low_cnt < 50) begin
      low_cnt++;
      tick();
    end
    check("hsync_width", 32'(low_cnt), 32'd3);
    check("hsync_end.hcount", 32'(vga.hcount), 32'd21);
    tick(3);
    check_all("h24", 24, 0, 1, 0, 1, 1, 0, 0);
    tick();
    check_all("line_wrap", 0, 1, 0, 0, 1, 1, 0, 0);

    // Vertical decode at the start of each line, then the frame wrap.
    for (int l = 1; l < 10; l++) begin
      check($sformatf("line%0d.vcount", l), 32'(vga.vcount), 32'(l));
      check($sformatf("line%0d.vblnk", l), 32'(vga.vblnk), 32'(vblnk_tab[l]));
      check($sformatf("line%0d.vsync", l), 32'(vga.vsync), 32'(vsync_tab[l]));
      tick(l == 9 ? 24 : 25);
    end
    check_all("last_pixel", 24, 9, 1, 1, 1, 1, 0, 0);
    tick();
    check_all("frame_wrap", 0, 0, 0, 0, 1, 1, 1, 1);
    tick();
    check_all("after_wrap", 1, 0, 0, 0, 1, 1, 0, 1);

    wait_frame_start(n);
    check("frame_period", 32'(n), 32'd249);
    check("frame2.frame_cnt", 32'(vga.frame_cnt), 32'd2);

    // Freeze inside the hsync pulse; enabled low cycles must still total 3.
    tick(17);
    check("pre_sync.hcount", 32'(vga.hcount), 32'd17);
    tick(2);
    check("in_sync.hsync", 32'(vga.hsync), 32'd0);
    en = 1'b0;
    tick(10);
    check_all("frozen", 19, 0, 1, 0, 0, 1, 0, 2);
    en = 1'b1;
    tick();
    check("resume.hcount", 32'(vga.hcount), 32'd20);
    check("resume.hsync", 32'(vga.hsync), 32'd0);
    tick();
    check("resume_end.hsync", 32'(vga.hsync), 32'd1);

    // Drop en on the frame_start cycle.
    wait_frame_start(n);
    check("fs3.seen", 32'(n > 0), 32'd1);
    check("fs3.frame_cnt", 32'(vga.frame_cnt), 32'd3);
    en = 1'b0;
    tick();
    check_all("fs_drop", 0, 0, 0, 0, 1, 1, 0, 3);
    tick(3);
    check_all("fs_hold", 0, 0, 0, 0, 1, 1, 0, 3);
    en = 1'b1;
    tick();
    check_all("fs_resume", 1, 0, 0, 0, 1, 1, 0, 3);

    // Mid-frame reset at (12,5).
    tick(136);
    check_all("pre_reset", 12, 5, 0, 0, 1, 1, 0, 3);
    rst = 1'b1;
    tick();
    check_all("mid_reset", 0, 0, 0, 0, 1, 1, 0, 0);
    rst = 1'b0;
    tick();
    check("post_reset.hcount", 32'(vga.hcount), 32'd1);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    tick();
    check("preload.frame_cnt", 32'(vga.frame_cnt), 32'hFFFF);
    wait_frame_start(n);
    check("wrap.seen", 32'(n > 0), 32'd1);
    check("wrap.frame_cnt", 32'(vga.frame_cnt), 32'h0000);
    tick();
    check("wrap_next.frame_start", 32'(vga.frame_start), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
